// File: rtl/dr_load_sequencer.sv
// -----------------------------------------------------------------------------
// dr_load_sequencer
//
// Assembles a 1..4 byte operand from a valid/ready byte stream into an external
// 32-bit data register. The data register is driven through its 8-bit input,
// write enable and 2-bit function select:
//   00 sign-extend load, 01 zero-extend load, 10 shift-left-8, 11 shift-right-8
//
// MSB-first commands load the first byte with extension and shift the rest in
// from the right. LSB-first commands shift every byte in from the left and then
// pad with fill bytes until four bytes have been written, so the first byte
// ends up in bits [7:0].
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-high reset
//   cmd_valid_i      command request
//   cmd_ready_o      command can be accepted (IDLE only)
//   cmd_len_i        byte count minus one
//   cmd_sign_ext_i   1 = sign-extend, 0 = zero-extend
//   cmd_order_i      0 = MSB-first, 1 = LSB-first
//   abort_i          synchronous abort back to IDLE
//   byte_valid_i     source byte valid
//   byte_data_i      source byte
//   byte_ready_o     sequencer accepts a byte
//   dr_i_o           data register byte input   (registered)
//   dr_e_o           data register write enable (registered, one cycle/write)
//   dr_fun_sel_o     data register function     (registered)
//   busy_o           command in progress
//   done_o           one-cycle pulse: data register holds the result
//   error_o          one-cycle pulse: byte source timed out
//
// TIMEOUT: consecutive LOAD cycles without byte_valid_i before giving up with
// error_o; 0 disables the timeout. The counter is 16 bits wide.
// -----------------------------------------------------------------------------
module dr_load_sequencer #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_len_i,
  input  logic       cmd_sign_ext_i,
  input  logic       cmd_order_i,
  input  logic       abort_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic [7:0] dr_i_o,
  output logic       dr_e_o,
  output logic [1:0] dr_fun_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] FS_SEXT = 2'b00;
  localparam logic [1:0] FS_ZEXT = 2'b01;
  localparam logic [1:0] FS_SHL  = 2'b10;
  localparam logic [1:0] FS_SHR  = 2'b11;

  localparam logic       TO_EN   = (TIMEOUT != 0);
  // Value of the idle counter on the cycle that completes the timeout window.
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  len_q, len_d;       // byte count minus one
  logic        sign_q, sign_d;
  logic        order_q, order_d;
  logic [2:0]  k_q, k_d;           // bytes written so far, pads included
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  pad_q, pad_d;
  logic [7:0]  dr_i_q, dr_i_d;
  logic        dr_e_q, dr_e_d;
  logic [1:0]  dr_fs_q, dr_fs_d;
  logic        error_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      len_q    <= 2'd0;
      sign_q   <= 1'b0;
      order_q  <= 1'b0;
      k_q      <= 3'd0;
      to_cnt_q <= 16'd0;
      pad_q    <= 8'd0;
      dr_i_q   <= 8'd0;
      dr_e_q   <= 1'b0;
      dr_fs_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      sign_q   <= sign_d;
      order_q  <= order_d;
      k_q      <= k_d;
      to_cnt_q <= to_cnt_d;
      pad_q    <= pad_d;
      dr_i_q   <= dr_i_d;
      dr_e_q   <= dr_e_d;
      dr_fs_q  <= dr_fs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    sign_d   = sign_q;
    order_d  = order_q;
    k_d      = k_q;
    to_cnt_d = to_cnt_q;
    pad_d    = pad_q;
    dr_i_d   = dr_i_q;
    dr_e_d   = 1'b0;
    dr_fs_d  = dr_fs_q;
    error_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // An abort in the same cycle drops the command.
        if (cmd_valid_i && !abort_i) begin
          state_d  = S_LOAD;
          len_d    = cmd_len_i;
          sign_d   = cmd_sign_ext_i;
          order_d  = cmd_order_i;
          k_d      = 3'd0;
          to_cnt_d = 16'd0;
        end
      end

      S_LOAD: begin
        if (abort_i) begin
          // The byte offered this cycle is consumed (ready was high) but
          // never written.
          state_d = S_IDLE;
        end else if (byte_valid_i) begin
          dr_e_d   = 1'b1;
          dr_i_d   = byte_data_i;
          k_d      = k_q + 3'd1;
          to_cnt_d = 16'd0;
          if (order_q) begin
            dr_fs_d = FS_SHR;
          end else if (k_q == 3'd0) begin
            dr_fs_d = sign_q ? FS_SEXT : FS_ZEXT;
          end else begin
            dr_fs_d = FS_SHL;
          end
          if (k_q[1:0] == len_q) begin
            // Fill byte for LSB-first padding follows the last byte's MSB.
            pad_d   = (sign_q && byte_data_i[7]) ? 8'hFF : 8'h00;
            state_d = (order_q && (len_q != 2'd3)) ? S_PAD : S_WAIT;
          end
        end else if (TO_EN) begin
          if (to_cnt_q == TO_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end
      end

      S_PAD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          dr_e_d  = 1'b1;
          dr_i_d  = pad_q;
          dr_fs_d = FS_SHR;
          k_d     = k_q + 3'd1;
          if (k_q == 3'd3) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        state_d = abort_i ? S_IDLE : S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign byte_ready_o = (state_q == S_LOAD);
  assign done_o       = (state_q == S_DONE) && !abort_i;
  assign error_o      = error_d;
  assign dr_i_o       = dr_i_q;
  assign dr_e_o       = dr_e_q;
  assign dr_fun_sel_o = dr_fs_q;

endmodule

// File: tb/tb_dr_load_sequencer.sv
module tb_dr_load_sequencer;

  localparam int TO = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_len;
  logic       cmd_sign_ext;
  logic       cmd_order;
  logic       abort;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [7:0] dr_i;
  logic       dr_e;
  logic [1:0] dr_fs;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  dr_load_sequencer #(.TIMEOUT(TO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_len_i     (cmd_len),
    .cmd_sign_ext_i(cmd_sign_ext),
    .cmd_order_i   (cmd_order),
    .abort_i       (abort),
    .byte_valid_i  (byte_valid),
    .byte_data_i   (byte_data),
    .byte_ready_o  (byte_ready),
    .dr_i_o        (dr_i),
    .dr_e_o        (dr_e),
    .dr_fun_sel_o  (dr_fs),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data register: no reset, behaves per its function-select encoding.
  logic [31:0] dr_model = 32'd0;
  always @(posedge clk) begin
    if (dr_e) begin
      case (dr_fs)
        2'b00: dr_model <= {{24{dr_i[7]}}, dr_i};
        2'b01: dr_model <= {24'd0, dr_i};
        2'b10: dr_model <= {dr_model[23:0], dr_i};
        default: dr_model <= {dr_i, dr_model[31:8]};
      endcase
    end
  end

  // Event monitor (cumulative; commands use deltas).
  int hs_total = 0, wr_total = 0, done_total = 0, err_total = 0, bad_total = 0;
  int last_hs_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [31:0] done_val = 32'd0;
  logic [7:0]  wr_i_q[$];
  logic [1:0]  wr_fs_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) begin
        hs_total++;
        last_hs_cyc = cyc;
      end
      if (dr_e) begin
        wr_total++;
        wr_i_q.push_back(dr_i);
        wr_fs_q.push_back(dr_fs);
        if (cmd_ready || done) bad_total++;
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        done_val = dr_model;
      end
      if (error) begin
        err_total++;
        err_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command; expectations come from the operand-assembly rules.
  task automatic run_cmd(input logic [1:0] len, input logic sgn, input logic ord,
                         input logic [3:0][7:0] b, input logic [3:0][3:0] g,
                         input bit do_abort);
    int n, pads, hs0, wr0, done0, err0, wi0, acc_cyc, lowrun, sent, sumg, exp_err_cyc, w;
    bit timed_out, aborted;
    logic [31:0] exp_val;
    logic [7:0]  pad, exp_i;
    logic [1:0]  exp_fs;
    n = int'(len) + 1;
    pads = (ord && n < 4) ? 4 - n : 0;
    timed_out = 0; aborted = 0; exp_err_cyc = 0;

    w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    hs0 = hs_total; wr0 = wr_total; done0 = done_total; err0 = err_total;
    wi0 = wr_i_q.size();
    cmd_valid = 1'b1; cmd_len = len; cmd_sign_ext = sgn; cmd_order = ord;
    acc_cyc = cyc;
    tick();
    cmd_valid = 1'b0;

    lowrun = 0; sent = 0; sumg = 0;
    for (int i = 0; i < n && !timed_out; i++) begin
      for (int j = 0; j < int'(g[i]) && !timed_out; j++) begin
        lowrun++;
        sumg++;
        if (lowrun == TO) begin
          timed_out = 1;
          exp_err_cyc = cyc;
        end
        tick();
      end
      if (!timed_out) begin
        byte_valid = 1'b1;
        byte_data = b[i];
        lowrun = 0;
        sent++;
        tick();
        byte_valid = 1'b0;
      end
    end

    if (timed_out) begin
      check_val("cmd_ready_after_err", 32'(cmd_ready), 32'd1);
    end else if (do_abort && pads > 0) begin
      tick();                 // second pad cycle
      abort = 1'b1;
      tick();
      abort = 1'b0;
      aborted = 1;
      check_val("cmd_ready_after_abort", 32'(cmd_ready), 32'd1);
    end

    repeat (8) tick();

    check_val("handshakes", 32'(hs_total - hs0), 32'(sent));
    if (timed_out) begin
      check_val("err_count", 32'(err_total - err0), 32'd1);
      check_val("err_cycle", 32'(err_cyc), 32'(exp_err_cyc));
      check_val("done_on_err", 32'(done_total - done0), 32'd0);
      check_val("writes_on_err", 32'(wr_total - wr0), 32'(sent));
    end else if (aborted) begin
      check_val("done_on_abort", 32'(done_total - done0), 32'd0);
      check_val("err_on_abort", 32'(err_total - err0), 32'd0);
      check_val("writes_on_abort", 32'(wr_total - wr0), 32'(n + 1));
    end else begin
      exp_val = 32'd0;
      if (!ord) begin
        for (int i = 0; i < n; i++) exp_val = (exp_val << 8) | 32'(b[i]);
        if (sgn && b[0][7]) for (int p = 8 * n; p < 32; p++) exp_val[p] = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) exp_val = exp_val | (32'(b[i]) << (8 * i));
        if (sgn && b[n-1][7]) for (int p = 8 * n; p < 32; p++) exp_val[p] = 1'b1;
      end
      pad = (sgn && b[n-1][7]) ? 8'hFF : 8'h00;
      check_val("done_count", 32'(done_total - done0), 32'd1);
      check_val("err_count", 32'(err_total - err0), 32'd0);
      check_val("writes", 32'(wr_total - wr0), 32'(n + pads));
      check_val("done_latency", 32'(done_cyc - acc_cyc), 32'(n + sumg + pads + 2));
      check_val("dr_value", done_val, exp_val);
      for (int i = 0; i < n + pads && (wi0 + i) < wr_i_q.size(); i++) begin
        exp_i  = (i < n) ? b[i] : pad;
        exp_fs = ord ? 2'b11 : ((i == 0) ? (sgn ? 2'b00 : 2'b01) : 2'b10);
        check_val("write_byte", 32'(wr_i_q[wi0 + i]), 32'(exp_i));
        check_val("write_funsel", 32'(wr_fs_q[wi0 + i]), 32'(exp_fs));
      end
    end
    $display("cmd len=%0d sign=%0d order=%0d bytes=%h gaps=%h abort=%0d timeout=%0d",
             n, sgn, ord, b, g, aborted, timed_out);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] b;
    logic [3:0][3:0] g;
    logic [1:0] len;
    logic sgn, ord;
    bit ab;
    int r;

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = 2'd0; cmd_sign_ext = 1'b0; cmd_order = 1'b0;
    abort = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_outputs", {24'd0, busy, byte_ready, dr_e, dr_fs, done, error, 1'b0}, 32'd0);
    check_val("rst_dr_i", 32'(dr_i), 32'd0);

    // Directed cases
    run_cmd(2'd0, 1'b1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h85}, 16'h0000, 0);
    run_cmd(2'd2, 1'b0, 1'b0, {8'h00, 8'h56, 8'h34, 8'h12}, 16'h0000, 0);
    run_cmd(2'd1, 1'b1, 1'b1, {8'h00, 8'h00, 8'hA2, 8'h34}, 16'h0000, 0);
    run_cmd(2'd3, 1'b0, 1'b1, {8'h12, 8'h34, 8'h56, 8'h78}, 16'h2222, 0);
    run_cmd(2'd1, 1'b0, 1'b0, {8'h00, 8'h00, 8'h22, 8'h11}, 16'h0050, 0);
    run_cmd(2'd0, 1'b1, 1'b1, {8'h00, 8'h00, 8'h00, 8'h9C}, 16'h0000, 1);

    // Reset in the middle of LOAD
    tick();
    cmd_valid = 1'b1; cmd_len = 2'd2; cmd_sign_ext = 1'b0; cmd_order = 1'b0;
    tick();
    cmd_valid = 1'b0; byte_valid = 1'b1; byte_data = 8'hC3;
    tick();
    byte_valid = 1'b0;
    check_val("pre_rst_dr_e", 32'(dr_e), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_outputs", {24'd0, busy, byte_ready, dr_e, dr_fs, done, error, 1'b0}, 32'd0);
    check_val("async_rst_dr_i", 32'(dr_i), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_cmd(2'd3, 1'b1, 1'b0, {8'h44, 8'h33, 8'h22, 8'hF1}, 16'h0000, 0);

    // Randomized commands
    for (int t = 0; t < 60; t++) begin
      len = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      ord = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        b[i] = 8'($urandom);
        r = $urandom_range(0, 19);
        if (r < 12) g[i] = 4'd0;
        else if (r < 18) g[i] = 4'($urandom_range(1, 3));
        else g[i] = 4'($urandom_range(4, 6));
      end
      ab = ($urandom_range(0, 4) == 0);
      run_cmd(len, sgn, ord, b, g, ab);
    end

    check_val("dr_e_in_idle_or_done", 32'(bad_total), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
